seq_signed_divider: RTL and testbench

//   Sequential signed integer divider, the inverse datapath of the shift-add

---
 rtl/seq_signed_divider_if.sv | 32 +++
 rtl/seq_signed_divider.sv | 120 ++++++++++++
 tb/tb_seq_signed_divider.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_signed_divider_if.sv
// ============================================================================
// Module  : seq_signed_divider_if
// Brief   : Start/busy/done handshake and operand/result bus for the
//           sequential signed divider.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_signed_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, A, B,
        input  Q, R, busy, done, div_by_zero
    );

    modport slave (
        input  start, A, B,
        output Q, R, busy, done, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/seq_signed_divider.sv
// ============================================================================
// Module  : seq_signed_divider
// Brief   : Radix-2 restoring signed divider, one quotient bit per clock,
//           quotient and remainder truncated toward zero, fixed latency.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_signed_divider #(
    parameter int WIDTH = 32
) (
    input  wire logic            clk,
    input  wire logic            rst,
    seq_signed_divider_if.slave  bus
);
    localparam int                 c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic               r_sign_q;
    logic               r_sign_r;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_r;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz_out;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic               w_fit;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_q_final;
    logic [WIDTH-1:0]   w_r_final;

    // Unsigned magnitudes; the most negative value maps to 2^(WIDTH-1).
    assign w_abs_a = bus.A[WIDTH-1] ? -bus.A : bus.A;
    assign w_abs_b = bus.B[WIDTH-1] ? -bus.B : bus.B;

    // The dividend magnitude sits in r_quo and shifts into the remainder MSB-first.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_div};
    assign w_fit      = ~w_trial[WIDTH];
    assign w_rem_next = w_fit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_fit};

    // A zero divisor naturally leaves rem=|A|, so R=A falls out; Q is forced to -1.
    assign w_q_final = r_dbz    ? {WIDTH{1'b1}}
                     : r_sign_q ? -w_quo_next : w_quo_next;
    assign w_r_final = r_sign_r ? -w_rem_next : w_rem_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_dbz     <= 1'b0;
            r_q       <= '0;
            r_r       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz_out <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state  <= ST_RUN;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_rem    <= '0;
                        r_quo    <= w_abs_a;
                        r_div    <= w_abs_b;
                        r_sign_q <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                        r_sign_r <= bus.A[WIDTH-1];
                        r_dbz    <= (bus.B == '0);
                    end
                end
                ST_RUN: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_q       <= w_q_final;
                        r_r       <= w_r_final;
                        r_dbz_out <= r_dbz;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.Q           = r_q;
    assign bus.R           = r_r;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz_out;
endmodule

`default_nettype wire

// File: tb/tb_seq_signed_divider.sv
// ============================================================================
// Module  : tb_seq_signed_divider
// Brief   : Self-checking bench: directed vector table, handshake corner
//           sequences and random back-to-back ops against a reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_signed_divider;
    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cycle = 0;
    int          checks = 0;
    int          failures = 0;
    int          done_count = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    seq_signed_divider_if #(.WIDTH(W)) bus ();

    seq_signed_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] a, b, q, r;
        logic         dbz;
    } vec_t;

    typedef struct {
        logic [W-1:0] a, b, q, r;
        logic         dbz;
        int unsigned  acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[14];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dbz);
        longint la, lb;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (b == '0) begin
            q = '1; r = a; dbz = 1'b1;
        end else begin
            q = W'(la / lb); r = W'(la % lb); dbz = 1'b0;
        end
    endtask

    // Called at a negedge; waits for idle, pulses start and records the expectation.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
        int n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            checks++; failures++;
            $display("FAIL busy_timeout: busy still 1 after %0d cycles, required 0", n);
        end
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        sb.push_back('{a: a, b: b, q: q, r: r, dbz: dbz, acc: cycle + 1});
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            done_count++;
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_done: done pulse with no op outstanding, required none");
            end else begin
                mon_e = sb.pop_front();
                check("Q", bus.Q, mon_e.q);
                check("R", bus.R, mon_e.r);
                check("div_by_zero", W'(bus.div_by_zero), W'(mon_e.dbz));
                check("latency", W'(cycle - mon_e.acc), W'(W));
                check("busy_at_done", W'(bus.busy), '0);
                check("invariant", bus.Q * mon_e.b + bus.R, mon_e.a);
                if (mon_e.b != '0) begin
                    checks++;
                    if ((bus.R[W-1] ? -bus.R : bus.R) >= (mon_e.b[W-1] ? -mon_e.b : mon_e.b)) begin
                        failures++;
                        $display("FAIL rem_bound: |R| of 0x%08h not below |B| of 0x%08h", bus.R, mon_e.b);
                    end
                end
            end
        end
    end

    initial begin
        logic [W-1:0] ra, rb, rq, rr;
        logic         rd;
        int           dc;

        vecs[0]  = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,          dbz: 1'b0};
        vecs[1]  = '{a: 32'hFFFFFF9C,   b: 32'd7,          q: 32'hFFFFFFF2,   r: 32'hFFFFFFFE,   dbz: 1'b0};
        vecs[2]  = '{a: 32'd100,        b: 32'hFFFFFFF9,   q: 32'hFFFFFFF2,   r: 32'd2,          dbz: 1'b0};
        vecs[3]  = '{a: 32'hFFFFFF9C,   b: 32'hFFFFFFF9,   q: 32'd14,         r: 32'hFFFFFFFE,   dbz: 1'b0};
        vecs[4]  = '{a: 32'd5,          b: 32'd0,          q: 32'hFFFFFFFF,   r: 32'd5,          dbz: 1'b1};
        vecs[5]  = '{a: 32'd9,          b: 32'd3,          q: 32'd3,          r: 32'd0,          dbz: 1'b0};
        vecs[6]  = '{a: 32'h80000000,   b: 32'hFFFFFFFF,   q: 32'h80000000,   r: 32'd0,          dbz: 1'b0};
        vecs[7]  = '{a: 32'h7FFFFFFF,   b: 32'd1,          q: 32'h7FFFFFFF,   r: 32'd0,          dbz: 1'b0};
        vecs[8]  = '{a: 32'd3,          b: 32'd10,         q: 32'd0,          r: 32'd3,          dbz: 1'b0};
        vecs[9]  = '{a: 32'hFFFFFFFB,   b: 32'd0,          q: 32'hFFFFFFFF,   r: 32'hFFFFFFFB,   dbz: 1'b1};
        vecs[10] = '{a: 32'h80000000,   b: 32'd2,          q: 32'hC0000000,   r: 32'd0,          dbz: 1'b0};
        vecs[11] = '{a: 32'h7FFFFFFF,   b: 32'h80000000,   q: 32'd0,          r: 32'h7FFFFFFF,   dbz: 1'b0};
        vecs[12] = '{a: 32'h80000000,   b: 32'h80000000,   q: 32'd1,          r: 32'd0,          dbz: 1'b0};
        vecs[13] = '{a: 32'hFFFFFFF9,   b: 32'd2,          q: 32'hFFFFFFFD,   r: 32'hFFFFFFFF,   dbz: 1'b0};

        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_Q", bus.Q, '0);
        check("reset_R", bus.R, '0);
        check("reset_busy", W'(bus.busy), '0);
        check("reset_done", W'(bus.done), '0);
        check("reset_dbz", W'(bus.div_by_zero), '0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++)
            issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);
        drain();

        // start while busy must be ignored
        dc = done_count;
        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 32'd1;
        bus.B     = 32'd1;
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (W + 4) @(negedge clk);
        check("ignored_start_dones", W'(done_count - dc), W'(1));

        // reset in the middle of an op aborts it silently
        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("midrst_Q", bus.Q, '0);
        check("midrst_R", bus.R, '0);
        check("midrst_busy", W'(bus.busy), '0);
        check("midrst_done", W'(bus.done), '0);
        check("midrst_dbz", W'(bus.div_by_zero), '0);
        dc = done_count;
        repeat (W + 5) @(negedge clk);
        check("no_done_after_reset", W'(done_count - dc), '0);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 0) rb = W'($urandom_range(0, 30)) - W'(15);
            if (i % 8 == 1) ra = W'($urandom_range(0, 200)) - W'(100);
            if (rb == '0) rb = 32'd3;
            model(ra, rb, rq, rr, rd);
            issue(ra, rb, rq, rr, rd);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
